io_rle_stream_loader: RTL
=========================

Name: io_rle_stream_loader

Overview:
Parametrised successor to the current IO path, which chains the decompressor and the DMA. It accepts run-length-compressed words from the external bus and expands them into a packed bitstream. It writes full DATA_W-bit words to accelerator memory at incrementing addresses from a per-session base, then signals completion. It adds selectable width, per-session base and length, back-pressure, abort and error reporting.

Parameters:
DATA_W, 16, width of input words and memory words; a run word is bit [DATA_W-1] = bit value, bits [DATA_W-2:0] = run count.
ADDR_W, 16, memory address width.
LEN_W, 16, width of the session word-count port.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-low reset.
load  input  1  session enable; rising edge in IDLE starts a session; low mid-session aborts.
base_addr  input  ADDR_W  first write address; sampled at session start.
word_len  input  LEN_W  number of memory words in the session; sampled at session start.
interrupt  input  1  Din valid strobe; one transfer per cycle while high.
Din  input  DATA_W  compressed run word.
in_ready  output  1  high when a Din transfer is accepted this cycle.
mem_we  output  1  one-cycle memory write strobe.
mem_addr  output  ADDR_W  write address, valid with mem_we.
mem_data  output  DATA_W  packed write data, valid with mem_we.
busy  output  1  high in RUN/EXPAND.
done  output  1  one-cycle pulse at successful session end.
err  output  1  sticky error flag; cleared at next session start.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; all outputs 0; packer, bit count, run count, word index cleared; load edge-detector history cleared.
- States: IDLE, RUN, EXPAND, DONE.
- Start: IDLE and load rises (load=1, previous load=0).
  - Capture base_addr and word_len; clear err, word index and packer.
  - If word_len==0, go to DONE; otherwise go to RUN.
- RUN: in_ready=1.
  - interrupt=1 accepts Din; latch bit=Din[DATA_W-1], run=Din[DATA_W-2:0].
  - run==0 is a legal no-op: stay in RUN.
  - run!=0: go to EXPAND.
- EXPAND: in_ready=0; each cycle shift one bit into the packer and decrement run.
  - Packing order: the first bit of a word lands in mem_data[0], the last in mem_data[DATA_W-1].
  - On the edge completing DATA_W bits: mem_we=1 for the next cycle, mem_data=packer, mem_addr=base+word index (mod 2^ADDR_W, wraps silently); word index increments; packer clears.
  - When run reaches 0, return to RUN.
  - When word index reaches word_len, go to DONE immediately. If run was nonzero at that point, remaining bits are discarded and err=1.
- DONE: done=1 for exactly one cycle, then IDLE. A new session needs load to fall and rise again.
- interrupt=1 while in_ready=0 (EXPAND or DONE): word dropped, err=1. interrupt in IDLE is ignored with no error.
- Abort: load=0 in RUN/EXPAND goes to IDLE next edge; partial packer contents discarded; no done; err unchanged.
- A simultaneous abort and final write: abort wins; that write is suppressed.
- Reset mid-session behaves as full reset.
- Latency: word accepted at edge E with run=k expands over edges E+1..E+k. in_ready is high again in the cycle after edge E+k.

Optional Feature:
IO_BULK_RUN_EN
- Defined: in EXPAND, when the packer is empty and run>=DATA_W, write a full word of the run bit in one cycle (mem_data all 0s or all 1s) and subtract DATA_W from run. Otherwise expand bit-serially.
- Undefined: strictly one bit per cycle.
- Data, addresses and err are identical either way; only cycle counts differ.

Test Plan:
- Reset: rst=0 with load=1 and interrupt=1 -> all outputs 0, state IDLE; no write after rst returns high until a new load rising edge.
- Basic (DATA_W=16): base=0x0100, len=2, Din=0x8010 then 0x0010 -> writes 0xFFFF@0x0100, then 0x0000@0x0101; done pulses once; err=0. Without the macro, first mem_we occurs 16 cycles after acceptance.
- Mixed runs: len=1, Din=0x8003, 0x0005, 0x8008 -> one write 0xFF07@base; done; err=0. Zero-run word 0x8000 inserted anywhere -> same result.
- Overrun and overflow: len=1, Din=0x8020 -> single write 0xFFFF, err=1, done pulses. interrupt held during EXPAND -> word dropped, err=1.
- Abort and wrap: base=0xFFFF, len=2, runs of 16 -> writes at 0xFFFF then 0x0000. Drop load after the first write -> no second write, no done. len=0 -> done one cycle after start, no writes.
- Macro on: Din=0x8040, len=4 -> four 0xFFFF writes on consecutive cycles.

Source files
------------

// File: rtl/io_rle_stream_loader.sv
// io_rle_stream_loader
//   Expands run-length-coded input words into a packed bitstream and writes
//   full DATA_W-bit words to memory at base_addr, base_addr+1, ... for
//   word_len words per session, then pulses done.
//
//   Run word format: Din[DATA_W-1] = bit value, Din[DATA_W-2:0] = run count.
//
//   Ports:
//     clk, rst         clock (rising edge), synchronous active-low reset
//     load             session enable: rising edge in IDLE starts, low aborts
//     base_addr        first write address, sampled at session start
//     word_len         words to write this session, sampled at session start
//     interrupt, Din   input valid strobe and run word
//     in_ready         input transfer accepted this cycle (RUN state)
//     mem_we/addr/data one-cycle memory write
//     busy             session in progress (RUN/EXPAND)
//     done             one-cycle pulse at successful session end
//     err              sticky error: overrun or dropped input word
//
//   Build option: define IO_BULK_RUN_EN to emit a whole word per cycle when
//   the packer is empty and the remaining run covers a full word. Data,
//   addresses and err are unchanged; only cycle counts differ.

module io_rle_stream_loader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  word_len,
    input  logic              interrupt,
    input  logic [DATA_W-1:0] Din,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned RUN_W = DATA_W - 1;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_EXPAND = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                load_q;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   packer_q, packer_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                bit_q, bit_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                in_ready_q, busy_q, done_q;

    // Expansion helpers
    logic                bulk;
    logic                word_done;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   fill_word;
    logic [RUN_W-1:0]    run_next;
    logic [LEN_W-1:0]    idx_inc;

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        packer_d  = packer_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        run_d     = run_q;
        err_d     = err_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        bulk      = 1'b0;
        word_done = 1'b0;
        fill_word = '0;
        run_next  = run_q;
        idx_inc   = idx_q + LEN_W'(1);
        // New bits enter at the top so the first bit ends up in bit 0
        shifted   = {bit_q, packer_q[DATA_W-1:1]};

`ifdef IO_BULK_RUN_EN
        bulk = (cnt_q == '0) && (run_q >= RUN_W'(DATA_W));
`endif

        unique case (state_q)
            S_IDLE: begin
                if (load && !load_q) begin
                    base_d   = base_addr;
                    len_d    = word_len;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    packer_d = '0;
                    cnt_d    = '0;
                    run_d    = '0;
                    state_d  = (word_len == '0) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                if (!load) begin
                    state_d = S_IDLE;
                end else if (interrupt) begin
                    bit_d = Din[DATA_W-1];
                    run_d = Din[DATA_W-2:0];
                    // A zero-length run is a legal no-op
                    if (Din[DATA_W-2:0] != '0) begin
                        state_d = S_EXPAND;
                    end
                end
            end

            S_EXPAND: begin
                if (interrupt) begin
                    err_d = 1'b1;
                end
                if (!load) begin
                    // Abort beats any write completing on this edge
                    state_d = S_IDLE;
                end else begin
                    if (bulk) begin
                        word_done = 1'b1;
                        fill_word = {DATA_W{bit_q}};
                        run_next  = run_q - RUN_W'(DATA_W);
                    end else begin
                        run_next = run_q - RUN_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            word_done = 1'b1;
                            fill_word = shifted;
                            cnt_d     = '0;
                            packer_d  = '0;
                        end else begin
                            cnt_d    = cnt_q + CNT_W'(1);
                            packer_d = shifted;
                        end
                    end
                    run_d = run_next;

                    if (word_done) begin
                        we_d   = 1'b1;
                        data_d = fill_word;
                        addr_d = base_q + ADDR_W'(idx_q);
                        idx_d  = idx_inc;
                    end

                    // Session full: leftover run bits are an overrun
                    if (word_done && (idx_inc == len_q)) begin
                        state_d = S_DONE;
                        if (run_next != '0) begin
                            err_d = 1'b1;
                        end
                    end else if (run_next == '0) begin
                        state_d = S_RUN;
                    end
                end
            end

            S_DONE: begin
                if (interrupt) begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            load_q     <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            packer_q   <= '0;
            cnt_q      <= '0;
            bit_q      <= 1'b0;
            run_q      <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            packer_q   <= packer_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            run_q      <= run_d;
            err_q      <= err_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            in_ready_q <= (state_d == S_RUN);
            busy_q     <= (state_d == S_RUN) || (state_d == S_EXPAND);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign in_ready = in_ready_q;
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
